wb_bus_arbiter: RTL and testbench
=================================

Name: wb_bus_arbiter

Overview:
- Shares one Wishbone slave port between the CPU's two master ports: the instruction port (m0) and the data port (m1).
- The slave port connects to memory today and to the L2 cache later.
- Grants whole bus cycles (CYC-framed) using round-robin priority.
- An optional watchdog converts a stalled slave transaction into RTY to the requesting master.

Parameters:
- DATA_W, 128, data width of the DAT_M and DAT_S buses.
- ADR_W, 28, line-address width.
- SEL_W, 16, byte-select width (DATA_W/8).
- TIMEOUT, 0, cycles a granted STB may wait for ACK/RTY before the arbiter forces RTY. 0 disables the watchdog.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- m0_CYC, m0_STB, m0_WE  in  1 each  instruction master cycle, strobe and write enable.
- m0_ADR  in  ADR_W  instruction master address.
- m0_SEL  in  SEL_W  instruction master byte selects.
- m0_DAT_M  in  DATA_W  instruction master write data.
- m0_DAT_S  out  DATA_W  read data to the instruction master.
- m0_ACK, m0_RTY  out  1 each  acknowledge and retry to the instruction master.
- m1_*  same set as m0_*  data master.
- s_CYC, s_STB, s_WE  out  1 each  to the slave.
- s_ADR  out  ADR_W  to the slave.
- s_SEL  out  SEL_W  to the slave.
- s_DAT_M  out  DATA_W  write data to the slave.
- s_DAT_S  in  DATA_W  read data from the slave.
- s_ACK, s_RTY  in  1 each  from the slave.
- gnt  out  2  one-hot current grant: 01 = m0, 10 = m1, 00 = idle.

Behaviour:
- State machine with three states: IDLE, G0, G1. The `gnt` output is decoded from the state and is registered.
- Priority register `last`, 1 bit, records the most recently granted master.
- Reset (RST high at an edge), applied in any state including mid-transaction:
  - state = IDLE, last = 1 (so m0 wins the first tie), watchdog counter = 0.
  - Effect on outputs: gnt = 00, s_CYC = s_STB = 0, m0/m1 ACK = RTY = 0.
  - An in-flight slave transaction is abandoned; the masters are reset by the same RST.
- IDLE transitions:
  - Only m0_CYC high: go to G0.
  - Only m1_CYC high: go to G1.
  - Both high: grant the master that is not `last`.
  - Neither high: stay in IDLE.
  - On entering Gx, set last = x.
- Gx transitions:
  - Stay in Gx while mx_CYC = 1, across any number of STB/ACK beats.
  - When mx_CYC = 0 at an edge, the grant is released in that same edge, using the IDLE rules with `last` already equal to x. A waiting other master is therefore granted with no idle cycle between bus cycles.
- Arbitration latency: a master raising CYC in IDLE at cycle t is first seen by the slave in cycle t+1.
- Forwarding while in Gx, all combinational:
  - s_CYC/STB/WE/ADR/SEL/DAT_M = mx_* .
  - mx_ACK = s_ACK, mx_RTY = s_RTY | wd_rty.
- Outputs to the non-granted master: ACK = 0, RTY = 0. Wishbone requires that master to hold CYC/STB/ADR until it is granted and acknowledged.
- Outputs in IDLE:
  - s_CYC = s_STB = s_WE = 0.
  - s_ADR, s_SEL and s_DAT_M = 0.
  - Both masters see ACK = RTY = 0.
- m0_DAT_S = m1_DAT_S = s_DAT_S, unconditionally. This is valid only when qualified by the master's own ACK.
- Stray s_ACK or s_RTY while in IDLE: ignored, not forwarded, no state change.
- Watchdog, active only when TIMEOUT > 0; width is clog2(TIMEOUT+1):
  - The counter increments on each edge where gnt != 00, s_STB = 1 and s_ACK = s_RTY = 0.
  - It clears on ACK, on RTY, on STB low, or on a grant change.
  - wd_rty = (count == TIMEOUT) & s_STB & ~s_ACK. It is forwarded as a one-cycle RTY to the granted master, and the counter then clears.
  - The grant is held until the master drops CYC.
- Simultaneous events: if m0 drops CYC in the same cycle that m1 raises it, m1 is granted at that edge.
- Starvation bound: a master never waits more than one complete bus cycle of the other master.

Test Plan:
1. Reset, then m0 read to ADR 0x0000010 with the slave ACKing 2 cycles after STB.
   - Required: gnt = 01 one cycle after m0_CYC rises.
   - m0_ACK pulses once with DAT_S = slave data; m1 sees no ACK.
2. m0 and m1 raise CYC in the same cycle, both doing writes, with m1 SEL = 0xFFFF.
   - Required: m0 is granted first (last = 1 after reset).
   - When m0 drops CYC, gnt goes 01 -> 10 at that edge with no 00 cycle.
   - The slave sees m1's ADR and SEL.
3. Both masters request continuously for 6 back-to-back single-beat cycles.
   - Required: grant order is m0, m1, m0, m1, m0, m1.
4. TIMEOUT = 8, slave never ACKs.
   - Required: m0_RTY pulses high for exactly 1 cycle, 8 cycles after STB is first seen with no ACK.
   - The counter returns to 0 and gnt stays 01 until m0_CYC drops.
5. Assert RST mid-transaction while in G1 with STB high.
   - Required: next cycle gnt = 00, s_CYC = 0, m1_ACK = 0.
   - The next m1 request after reset is granted normally.
6. Slave drives s_ACK = 1 while in IDLE.
   - Required: m0_ACK = m1_ACK = 0 and state stays IDLE.

Source files
------------

// File: rtl/wb_bus_arbiter_if.sv
// Wishbone bus bundle shared by the arbiter's master-facing and slave-facing ports.
// "master" is the view of the device that starts cycles; "slave" is the responder.
interface wb_bus_arbiter_if #(
    parameter int DATA_W = 128,
    parameter int ADR_W  = 28,
    parameter int SEL_W  = 16
);
    logic              CYC;
    logic              STB;
    logic              WE;
    logic [ADR_W-1:0]  ADR;
    logic [SEL_W-1:0]  SEL;
    logic [DATA_W-1:0] DAT_M;
    logic [DATA_W-1:0] DAT_S;
    logic              ACK;
    logic              RTY;

    modport master (
        output CYC, STB, WE, ADR, SEL, DAT_M,
        input  DAT_S, ACK, RTY
    );

    modport slave (
        input  CYC, STB, WE, ADR, SEL, DAT_M,
        output DAT_S, ACK, RTY
    );
endinterface

// File: rtl/wb_bus_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave between the CPU instruction (m0)
// and data (m1) ports, granting whole CYC-framed cycles, with an optional RTY watchdog.
module wb_bus_arbiter #(
    parameter int DATA_W  = 128,
    parameter int ADR_W   = 28,
    parameter int SEL_W   = 16,
    parameter int TIMEOUT = 0
) (
    input  logic              CLK,
    input  logic              RST,
    wb_bus_arbiter_if.slave   m0,
    wb_bus_arbiter_if.slave   m1,
    wb_bus_arbiter_if.master  s,
    output logic [1:0]        gnt
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        G0   = 2'b01,
        G1   = 2'b10
    } state_e;

    state_e state_q, state_d;
    logic   last_q, last_d;
    logic   wd_rty;

    logic              s_cyc, s_stb, s_we;
    logic [ADR_W-1:0]  s_adr;
    logic [SEL_W-1:0]  s_sel;
    logic [DATA_W-1:0] s_dat_m;

    // Tie goes to the master that was not granted most recently.
    function automatic state_e arbitrate(input logic c0, input logic c1, input logic last);
        if (c0 && c1) return last ? G0 : G1;
        else if (c0)  return G0;
        else if (c1)  return G1;
        else          return IDLE;
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = arbitrate(m0.CYC, m1.CYC, last_q);
            G0:      state_d = m0.CYC ? G0 : arbitrate(m0.CYC, m1.CYC, last_q);
            G1:      state_d = m1.CYC ? G1 : arbitrate(m0.CYC, m1.CYC, last_q);
            default: state_d = IDLE;
        endcase

        last_d = last_q;
        if (state_d == G0) last_d = 1'b0;
        if (state_d == G1) last_d = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        gnt     = 2'b00;
        s_cyc   = 1'b0;
        s_stb   = 1'b0;
        s_we    = 1'b0;
        s_adr   = '0;
        s_sel   = '0;
        s_dat_m = '0;
        m0.ACK  = 1'b0;
        m0.RTY  = 1'b0;
        m1.ACK  = 1'b0;
        m1.RTY  = 1'b0;
        case (state_q)
            G0: begin
                gnt     = 2'b01;
                s_cyc   = m0.CYC;
                s_stb   = m0.STB;
                s_we    = m0.WE;
                s_adr   = m0.ADR;
                s_sel   = m0.SEL;
                s_dat_m = m0.DAT_M;
                m0.ACK  = s.ACK;
                m0.RTY  = s.RTY | wd_rty;
            end
            G1: begin
                gnt     = 2'b10;
                s_cyc   = m1.CYC;
                s_stb   = m1.STB;
                s_we    = m1.WE;
                s_adr   = m1.ADR;
                s_sel   = m1.SEL;
                s_dat_m = m1.DAT_M;
                m1.ACK  = s.ACK;
                m1.RTY  = s.RTY | wd_rty;
            end
            default: ;
        endcase
    end

    assign s.CYC    = s_cyc;
    assign s.STB    = s_stb;
    assign s.WE     = s_we;
    assign s.ADR    = s_adr;
    assign s.SEL    = s_sel;
    assign s.DAT_M  = s_dat_m;
    // Read data is only meaningful alongside the master's own ACK.
    assign m0.DAT_S = s.DAT_S;
    assign m1.DAT_S = s.DAT_S;

    if (TIMEOUT > 0) begin : g_wd
        localparam int WD_W = $clog2(TIMEOUT + 1);
        logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;

        always_comb begin
            wd_rty   = (wd_cnt_q == WD_W'(TIMEOUT)) && s_stb && !s.ACK;
            wd_cnt_d = wd_cnt_q;
            // A forced RTY ends the wait just like a slave RTY would.
            if ((state_d != state_q) || !s_stb || s.ACK || s.RTY || wd_rty)
                wd_cnt_d = '0;
            else if (state_q != IDLE)
                wd_cnt_d = wd_cnt_q + 1'b1;
        end

        always_ff @(posedge CLK) begin
            if (RST) wd_cnt_q <= '0;
            else     wd_cnt_q <= wd_cnt_d;
        end
    end else begin : g_no_wd
        assign wd_rty = 1'b0;
    end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed bench for wb_bus_arbiter: grant latency, round robin, hand-over, watchdog, reset.
module tb_wb_bus_arbiter;
    localparam int DATA_W  = 128;
    localparam int ADR_W   = 28;
    localparam int SEL_W   = 16;
    localparam int TIMEOUT = 8;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [1:0] gnt;
    int checks = 0;
    int errors = 0;

    wb_bus_arbiter_if #(.DATA_W(DATA_W), .ADR_W(ADR_W), .SEL_W(SEL_W)) m0_if ();
    wb_bus_arbiter_if #(.DATA_W(DATA_W), .ADR_W(ADR_W), .SEL_W(SEL_W)) m1_if ();
    wb_bus_arbiter_if #(.DATA_W(DATA_W), .ADR_W(ADR_W), .SEL_W(SEL_W)) s_if ();

    wb_bus_arbiter #(.DATA_W(DATA_W), .ADR_W(ADR_W), .SEL_W(SEL_W), .TIMEOUT(TIMEOUT)) dut (
        .CLK (CLK),
        .RST (RST),
        .m0  (m0_if),
        .m1  (m1_if),
        .s   (s_if),
        .gnt (gnt)
    );

    always #5 CLK = ~CLK;

    task automatic idle_inputs();
        m0_if.CYC = 0; m0_if.STB = 0; m0_if.WE = 0; m0_if.ADR = '0; m0_if.SEL = '0; m0_if.DAT_M = '0;
        m1_if.CYC = 0; m1_if.STB = 0; m1_if.WE = 0; m1_if.ADR = '0; m1_if.SEL = '0; m1_if.DAT_M = '0;
        s_if.ACK = 0; s_if.RTY = 0; s_if.DAT_S = '0;
    endtask

    // Leaves time at 1 ns after the reset edge, with the design in IDLE.
    task automatic do_reset();
        @(posedge CLK); #1;
        RST = 1'b1;
        idle_inputs();
        @(posedge CLK); #1;
        RST = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge CLK); #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b expected 00", gnt); end
        checks++; if (s_if.CYC !== 1'b0 || s_if.STB !== 1'b0) begin errors++; $display("FAIL reset_s_cyc_stb: got %b%b expected 00", s_if.CYC, s_if.STB); end
        checks++; if ({m0_if.ACK, m0_if.RTY, m1_if.ACK, m1_if.RTY} !== 4'b0) begin errors++; $display("FAIL reset_ack_rty: got %b expected 0000", {m0_if.ACK, m0_if.RTY, m1_if.ACK, m1_if.RTY}); end
        checks++; if (s_if.ADR !== '0) begin errors++; $display("FAIL reset_s_adr: got %h expected 0", s_if.ADR); end
    endtask

    task automatic test_m0_read();
        logic [DATA_W-1:0] rd;
        rd = {32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hCAFEF00D};
        do_reset();
        m0_if.CYC = 1; m0_if.STB = 1; m0_if.WE = 0; m0_if.ADR = 28'h0000010; m0_if.SEL = 16'hFFFF;
        #1;
        checks++; if (s_if.CYC !== 1'b0) begin errors++; $display("FAIL rd_latency_s_cyc: got %b expected 0", s_if.CYC); end
        next_cycle();
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL rd_gnt: got %b expected 01", gnt); end
        checks++; if (s_if.CYC !== 1'b1 || s_if.ADR !== 28'h0000010) begin errors++; $display("FAIL rd_s_fwd: got cyc=%b adr=%h expected cyc=1 adr=0000010", s_if.CYC, s_if.ADR); end
        next_cycle();
        checks++; if (m0_if.ACK !== 1'b0) begin errors++; $display("FAIL rd_early_ack: got %b expected 0", m0_if.ACK); end
        next_cycle();
        s_if.ACK = 1; s_if.DAT_S = rd;
        #1;
        checks++; if (m0_if.ACK !== 1'b1) begin errors++; $display("FAIL rd_m0_ack: got %b expected 1", m0_if.ACK); end
        checks++; if (m0_if.DAT_S !== rd) begin errors++; $display("FAIL rd_m0_dat: got %h expected %h", m0_if.DAT_S, rd); end
        checks++; if (m1_if.ACK !== 1'b0) begin errors++; $display("FAIL rd_m1_ack: got %b expected 0", m1_if.ACK); end
        next_cycle();
        s_if.ACK = 0; m0_if.CYC = 0; m0_if.STB = 0;
        #1;
        checks++; if (m0_if.ACK !== 1'b0) begin errors++; $display("FAIL rd_ack_once: got %b expected 0", m0_if.ACK); end
        next_cycle();
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL rd_release: got %b expected 00", gnt); end
    endtask

    task automatic test_contention();
        logic [DATA_W-1:0] da, db;
        da = {4{32'hA5A5A5A5}};
        db = {4{32'h5A5A0F0F}};
        do_reset();
        m0_if.CYC = 1; m0_if.STB = 1; m0_if.WE = 1; m0_if.ADR = 28'h0000020; m0_if.SEL = 16'h000F; m0_if.DAT_M = da;
        m1_if.CYC = 1; m1_if.STB = 1; m1_if.WE = 1; m1_if.ADR = 28'h0000030; m1_if.SEL = 16'hFFFF; m1_if.DAT_M = db;
        next_cycle();
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL tie_first_gnt: got %b expected 01", gnt); end
        checks++; if (s_if.ADR !== 28'h0000020 || s_if.WE !== 1'b1 || s_if.DAT_M !== da) begin errors++; $display("FAIL tie_m0_fwd: got adr=%h we=%b expected adr=0000020 we=1", s_if.ADR, s_if.WE); end
        s_if.ACK = 1;
        #1;
        checks++; if (m0_if.ACK !== 1'b1 || m1_if.ACK !== 1'b0) begin errors++; $display("FAIL tie_ack_route: got m0=%b m1=%b expected m0=1 m1=0", m0_if.ACK, m1_if.ACK); end
        next_cycle();
        s_if.ACK = 0; m0_if.CYC = 0; m0_if.STB = 0;
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL tie_hold_gnt: got %b expected 01", gnt); end
        next_cycle();
        checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL tie_handover: got %b expected 10", gnt); end
        checks++; if (s_if.ADR !== 28'h0000030 || s_if.SEL !== 16'hFFFF || s_if.DAT_M !== db) begin errors++; $display("FAIL tie_m1_fwd: got adr=%h sel=%h expected adr=0000030 sel=ffff", s_if.ADR, s_if.SEL); end
        s_if.ACK = 1;
        #1;
        checks++; if (m1_if.ACK !== 1'b1 || m0_if.ACK !== 1'b0) begin errors++; $display("FAIL tie_m1_ack: got m0=%b m1=%b expected m0=0 m1=1", m0_if.ACK, m1_if.ACK); end
        next_cycle();
        s_if.ACK = 0; m1_if.CYC = 0; m1_if.STB = 0;
        next_cycle();
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL tie_idle: got %b expected 00", gnt); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_gnt;
        do_reset();
        m0_if.CYC = 1; m0_if.STB = 1; m0_if.ADR = 28'h0000100;
        m1_if.CYC = 1; m1_if.STB = 1; m1_if.ADR = 28'h0000200;
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            m0_if.CYC = 1; m0_if.STB = 1;
            m1_if.CYC = 1; m1_if.STB = 1;
            exp_gnt = (i % 2 == 0) ? 2'b01 : 2'b10;
            checks++; if (gnt !== exp_gnt) begin errors++; $display("FAIL b2b_gnt[%0d]: got %b expected %b", i, gnt, exp_gnt); end
            s_if.ACK = 1;
            #1;
            checks++; if ({m1_if.ACK, m0_if.ACK} !== exp_gnt) begin errors++; $display("FAIL b2b_ack[%0d]: got %b expected %b", i, {m1_if.ACK, m0_if.ACK}, exp_gnt); end
            next_cycle();
            s_if.ACK = 0;
            if (exp_gnt == 2'b01) begin m0_if.CYC = 0; m0_if.STB = 0; end
            else                  begin m1_if.CYC = 0; m1_if.STB = 0; end
        end
        idle_inputs();
        next_cycle();
        next_cycle();
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL b2b_idle: got %b expected 00", gnt); end
    endtask

    task automatic test_watchdog();
        logic exp_rty;
        do_reset();
        m0_if.CYC = 1; m0_if.STB = 1; m0_if.ADR = 28'h0000040;
        next_cycle();
        for (int k = 0; k <= 17; k++) begin
            exp_rty = (k == 8) || (k == 17);
            checks++; if (m0_if.RTY !== exp_rty) begin errors++; $display("FAIL wd_rty[%0d]: got %b expected %b", k, m0_if.RTY, exp_rty); end
            if (k == 8) begin
                checks++; if (m1_if.RTY !== 1'b0) begin errors++; $display("FAIL wd_m1_rty: got %b expected 0", m1_if.RTY); end
            end
            if (k == 9) begin
                checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL wd_gnt_held: got %b expected 01", gnt); end
            end
            if (k < 17) next_cycle();
        end
        m0_if.CYC = 0; m0_if.STB = 0;
        next_cycle();
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL wd_release: got %b expected 00", gnt); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        m1_if.CYC = 1; m1_if.STB = 1; m1_if.WE = 1; m1_if.ADR = 28'h0000050;
        next_cycle();
        checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL rst_mid_pre_gnt: got %b expected 10", gnt); end
        RST = 1;
        next_cycle();
        s_if.ACK = 1;
        #1;
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL rst_mid_gnt: got %b expected 00", gnt); end
        checks++; if (s_if.CYC !== 1'b0) begin errors++; $display("FAIL rst_mid_s_cyc: got %b expected 0", s_if.CYC); end
        checks++; if (m1_if.ACK !== 1'b0) begin errors++; $display("FAIL rst_mid_m1_ack: got %b expected 0", m1_if.ACK); end
        RST = 0; s_if.ACK = 0;
        next_cycle();
        checks++; if (gnt !== 2'b10 || s_if.ADR !== 28'h0000050) begin errors++; $display("FAIL rst_mid_regrant: got gnt=%b adr=%h expected gnt=10 adr=0000050", gnt, s_if.ADR); end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_idle_ack();
        do_reset();
        s_if.ACK = 1; s_if.RTY = 1;
        #1;
        checks++; if ({m0_if.ACK, m1_if.ACK, m0_if.RTY, m1_if.RTY} !== 4'b0) begin errors++; $display("FAIL idle_stray: got %b expected 0000", {m0_if.ACK, m1_if.ACK, m0_if.RTY, m1_if.RTY}); end
        next_cycle();
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL idle_stay: got %b expected 00", gnt); end
        s_if.ACK = 0; s_if.RTY = 0;
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_m0_read();
        test_contention();
        test_back_to_back();
        test_watchdog();
        test_reset_mid();
        test_idle_ack();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout: got no completion expected finish before 200000 ns");
        $fatal(1, "timeout");
    end
endmodule
